// File: rtl/acc_sat_n.sv
// Frame accumulator: sums CNT signed samples and emits one saturated
// signed result per frame, with a per-frame saturation flag.
module acc_sat_n #(
    parameter int ARG_WIDTH = 32,
    parameter int RES_WIDTH = ARG_WIDTH,
    parameter int CNT       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        arg_vld,
    input  logic signed [ARG_WIDTH-1:0] a,
    output logic                        res_vld,
    output logic signed [RES_WIDTH-1:0] res,
    output logic                        overflow
);

    localparam int CW = $clog2(CNT);
    localparam int AW = ARG_WIDTH + CW + 1;

    localparam logic signed [AW-1:0] RMAX =
        {{(AW-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] RMIN = ~RMAX;
    localparam logic [CW-1:0] LAST = CW'(CNT - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 res_vld_q, res_vld_d;
    logic [RES_WIDTH-1:0] res_q, res_d;
    logic                 ovf_q, ovf_d;

    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] sum;
    logic [RES_WIDTH-1:0] sat_res;
    logic                 sat_ovf;
    logic                 last;

    assign a_ext = {{(AW-ARG_WIDTH){a[ARG_WIDTH-1]}}, a};
    assign sum   = acc_q + a_ext;
    assign last  = arg_vld && (cnt_q == LAST);

    always_comb begin
        sat_res = sum[RES_WIDTH-1:0];
        sat_ovf = 1'b0;
        if (sum > RMAX) begin
            sat_res = RMAX[RES_WIDTH-1:0];
            sat_ovf = 1'b1;
        end else if (sum < RMIN) begin
            sat_res = RMIN[RES_WIDTH-1:0];
            sat_ovf = 1'b1;
        end
    end

    // clr wins over a coincident sample, including the frame-closing one
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        res_vld_d = 1'b0;
        res_d     = res_q;
        ovf_d     = ovf_q;
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (last) begin
            cnt_d     = '0;
            acc_d     = '0;
            res_vld_d = 1'b1;
            res_d     = sat_res;
            ovf_d     = sat_ovf;
        end else if (arg_vld) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            res_vld_q <= res_vld_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
        end
    end

    assign res_vld  = res_vld_q;
    assign res      = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_acc_sat_n.sv
// Bench for acc_sat_n: directed 8/8/4 scenarios plus a randomized
// 16/12/7 regression against an exact-sum saturation model.
module tb_acc_sat_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic              rst0, clr0, vld0;
    logic signed [7:0] a0;
    logic              res_vld0;
    logic signed [7:0] res0;
    logic              ovf0;

    logic               rst1, clr1, vld1;
    logic signed [15:0] a1;
    logic               res_vld1;
    logic signed [11:0] res1;
    logic               ovf1;

    acc_sat_n #(.ARG_WIDTH(8), .RES_WIDTH(8), .CNT(4)) dut0 (
        .clk(clk), .rst(rst0), .clr(clr0), .arg_vld(vld0), .a(a0),
        .res_vld(res_vld0), .res(res0), .overflow(ovf0)
    );

    acc_sat_n #(.ARG_WIDTH(16), .RES_WIDTH(12), .CNT(7)) dut1 (
        .clk(clk), .rst(rst1), .clr(clr1), .arg_vld(vld1), .a(a1),
        .res_vld(res_vld1), .res(res1), .overflow(ovf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit v, input int x, input bit c);
        vld0 = v;
        a0   = 8'(x);
        clr0 = c;
        step();
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        clr0 = 0; vld0 = 0; a0 = '0;
        clr1 = 0; vld1 = 0; a1 = '0;
        step();
        checks++;
        if ({res_vld0, ovf0, res0} !== 10'd0) begin
            errors++;
            $display("FAIL reset0: vld=%b ovf=%b res=%0d, want 0/0/0",
                     res_vld0, ovf0, res0);
        end
        checks++;
        if ({res_vld1, ovf1, res1} !== 14'd0) begin
            errors++;
            $display("FAIL reset1: vld=%b ovf=%b res=%0d, want 0/0/0",
                     res_vld1, ovf1, res1);
        end
        #3;
        rst0 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_basic();
        int v[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            drive0(1, v[i], 0);
            checks++;
            if (res_vld0 !== (i == 3)) begin
                errors++;
                $display("FAIL basic_vld[%0d]: got %b want %b",
                         i, res_vld0, i == 3);
            end
        end
        checks++;
        if (res0 !== 8'sd100 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_res: res=%0d ovf=%b, want 100/0", res0, ovf0);
        end
        drive0(0, 0, 0);
        drive0(0, 0, 0);
        checks++;
        if (res_vld0 !== 1'b0 || res0 !== 8'sd100) begin
            errors++;
            $display("FAIL basic_hold: vld=%b res=%0d, want 0/100",
                     res_vld0, res0);
        end
    endtask

    task automatic test_saturate();
        int v[4]   = '{100, 100, 0, 0};
        int gap[4] = '{0, 3, 1, 0};
        int n[4]   = '{-100, -100, -1, 0};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive0(1, v[i], 0);
            if (res_vld0 === 1'b1) pulses++;
            for (int g = 0; g < gap[i]; g++) begin
                drive0(0, 77, 0);
                if (res_vld0 === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses != 1 || res0 !== 8'sd127 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: pulses=%0d res=%0d ovf=%b, want 1/127/1",
                     pulses, res0, ovf0);
        end
        for (int i = 0; i < 4; i++) drive0(1, n[i], 0);
        checks++;
        if (res_vld0 !== 1'b1 || res0 !== -8'sd128 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: vld=%b res=%0d ovf=%b, want 1/-128/1",
                     res_vld0, res0, ovf0);
        end
        drive0(0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int v[8] = '{1, 1, 1, 1, 2, 2, 2, 2};
        for (int i = 0; i < 8; i++) begin
            drive0(1, v[i], 0);
            checks++;
            if (res_vld0 !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_vld[%0d]: got %b", i, res_vld0);
            end
            if (i == 3 || i == 7) begin
                checks++;
                if (res0 !== 8'((i == 3) ? 4 : 8) || ovf0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_res[%0d]: res=%0d ovf=%b, want %0d/0",
                             i, res0, ovf0, (i == 3) ? 4 : 8);
                end
            end
        end
        drive0(0, 0, 0);
        checks++;
        if (res_vld0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: res_vld=%b want 0", res_vld0);
        end
    endtask

    task automatic test_clear();
        int pulses = 0;
        drive0(1, 5, 0);
        drive0(1, 5, 0);
        drive0(1, 50, 1);
        for (int i = 1; i <= 4; i++) begin
            drive0(1, i, 0);
            if (res_vld0 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || res_vld0 !== 1'b1 || res0 !== 8'sd10 ||
            ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_frame: pulses=%0d res=%0d ovf=%b, want 1/10/0",
                     pulses, res0, ovf0);
        end
        // clr right after the last sample must not cancel the pulse
        drive0(0, 0, 1);
        checks++;
        if (res_vld0 !== 1'b0 || res0 !== 8'sd10) begin
            errors++;
            $display("FAIL clr_keep: vld=%b res=%0d, want 0/10",
                     res_vld0, res0);
        end
        drive0(1, 1, 0);
        drive0(1, 1, 0);
        drive0(1, 1, 0);
        drive0(1, 1, 1);
        checks++;
        if (res_vld0 !== 1'b0 || res0 !== 8'sd10) begin
            errors++;
            $display("FAIL clr_last: vld=%b res=%0d, want 0/10",
                     res_vld0, res0);
        end
        for (int i = 0; i < 4; i++) drive0(1, 3, 0);
        checks++;
        if (res_vld0 !== 1'b1 || res0 !== 8'sd12) begin
            errors++;
            $display("FAIL clr_after: vld=%b res=%0d, want 1/12",
                     res_vld0, res0);
        end
        drive0(0, 0, 0);
    endtask

    task automatic test_async_reset();
        int v[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) drive0(1, v[i], 0);
        drive0(1, 7, 0);
        drive0(1, 9, 0);
        checks++;
        if (res0 !== 8'sd100) begin
            errors++;
            $display("FAIL arst_pre: res=%0d want 100", res0);
        end
        #2;
        rst0 = 1'b1;
        #1;
        checks++;
        if ({res_vld0, ovf0, res0} !== 10'd0) begin
            errors++;
            $display("FAIL arst_now: vld=%b ovf=%b res=%0d, want 0/0/0",
                     res_vld0, ovf0, res0);
        end
        #2;
        rst0 = 1'b0;
        for (int i = 0; i < 4; i++) drive0(1, 1, 0);
        checks++;
        if (res_vld0 !== 1'b1 || res0 !== 8'sd4 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL arst_post: vld=%b res=%0d ovf=%b, want 1/4/0",
                     res_vld0, res0, ovf0);
        end
        drive0(0, 0, 0);
    endtask

    task automatic test_random();
        longint sum = 0;
        int     n = 0;
        bit     exp_vld = 0;
        longint exp_res = 0;
        bit     exp_ovf = 0;
        int     dens;
        int     frames = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) dens = $urandom_range(20, 100);
            vld1 = ($urandom_range(0, 99) < dens);
            clr1 = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1)
                a1 = 16'($urandom_range(0, 600) - 300);
            else
                a1 = 16'($urandom);
            exp_vld = 0;
            if (clr1) begin
                sum = 0;
                n = 0;
            end else if (vld1) begin
                sum += longint'(a1);
                n++;
                if (n == 7) begin
                    exp_vld = 1;
                    exp_ovf = (sum > 2047) || (sum < -2048);
                    exp_res = (sum > 2047) ? 2047 :
                              (sum < -2048) ? -2048 : sum;
                    sum = 0;
                    n = 0;
                    frames++;
                end
            end
            step();
            checks++;
            if (res_vld1 !== exp_vld || ovf1 !== exp_ovf ||
                longint'(res1) !== exp_res) begin
                errors++;
                $display("FAIL rand[%0d]: vld=%b ovf=%b res=%0d, want %b/%b/%0d",
                         cyc, res_vld1, ovf1, res1, exp_vld, exp_ovf, exp_res);
            end
        end
        checks++;
        if (frames < 50) begin
            errors++;
            $display("FAIL rand_frames: got %0d frames, want >= 50", frames);
        end
        vld1 = 0;
        clr1 = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
